// File: rtl/ballot_input_conditioner.sv
// ballot_input_conditioner: debounces voter/official buttons and issues one vote per armed ballot
module ballot_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LOCKOUT_CYCLES  = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_cand,
    input  logic       btn_confirm,
    input  logic       btn_clear,
    input  logic       btn_arm,
    input  logic       vote_ready,
    output logic       vote_valid,
    output logic [3:0] vote_onehot,
    output logic [1:0] vote_idx,
    output logic [3:0] sel_onehot,
    output logic       busy,
    output logic       err_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SELECT  = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;
    localparam logic [1:0] LOCKOUT = 2'd3;

    logic [6:0]    raw, sync1, sync2, deb, deb_prev, rise;
    logic [DW-1:0] cnt [7];
    logic [LW-1:0] lcnt;
    logic [1:0]    state;
    logic [3:0]    sel;
    logic          err, single;

    // bit order: cand[3:0], confirm, clear, arm
    assign raw    = {btn_arm, btn_clear, btn_confirm, btn_cand};
    assign rise   = deb & ~deb_prev;
    assign single = (deb[3:0] != 4'd0) && ((deb[3:0] & (deb[3:0] - 4'd1)) == 4'd0);

    // two-flop synchronizers and per-button debounce counters
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 7; i++) cnt[i] <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            deb_prev <= deb;
            for (int i = 0; i < 7; i++) begin
                if (sync2[i] == deb[i]) cnt[i] <= '0;
                else if (cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i] <= '0;
                    deb[i] <= sync2[i];
                end else cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // ballot FSM: clear beats confirm beats candidate while selecting
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= '0;
            err   <= 1'b0;
            lcnt  <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: if (rise[6]) state <= SELECT;
                SELECT: begin
                    if (rise[5]) sel <= '0;
                    else if (rise[4]) begin
                        if (sel != 4'd0) state <= SEND;
                        else err <= 1'b1;
                    end else if (|rise[3:0]) begin
                        if (single) sel <= deb[3:0];
                        else err <= 1'b1;
                    end
                end
                SEND: if (vote_ready) begin
                    state <= LOCKOUT;
                    sel   <= '0;
                    lcnt  <= LW'(LOCKOUT_CYCLES);
                end
                default: if (lcnt == LW'(1)) state <= IDLE;
                         else lcnt <= lcnt - 1'b1;
            endcase
        end
    end

    assign vote_valid  = state == SEND;
    assign vote_onehot = vote_valid ? sel : 4'd0;
    assign vote_idx    = vote_valid ? {sel[3] | sel[2], sel[3] | sel[1]} : 2'd0;
    assign sel_onehot  = sel;
    assign busy        = state != IDLE;
    assign err_pulse   = err;
endmodule

// File: tb/tb_ballot_input_conditioner.sv
// tb_ballot_input_conditioner: randomized sessions checked against a sample-window reference model
module tb_ballot_input_conditioner;
    localparam int D = 4;
    localparam int L = 8;
    localparam logic [6:0] ARM  = 7'h40;
    localparam logic [6:0] CLR  = 7'h20;
    localparam logic [6:0] CONF = 7'h10;

    typedef enum int {M_IDLE, M_SELECT, M_SEND, M_LOCK} mst_t;

    logic       clk = 0, rst = 1;
    logic [3:0] btn_cand = '0;
    logic       btn_confirm = 0, btn_clear = 0, btn_arm = 0, vote_ready = 0;
    logic       vote_valid, busy, err_pulse;
    logic [3:0] vote_onehot, sel_onehot;
    logic [1:0] vote_idx;
    logic [6:0] raw_in;
    bit         ready_hi = 0, ready_lo = 0;

    int vectors = 0, miscompares = 0, votes = 0;

    mst_t       mstate = M_IDLE;
    logic [3:0] msel = '0;
    logic       merr = 0;
    logic [6:0] mdeb = '0, pend = '0;
    logic [6:0] hist[$];
    logic [3:0] exp_q[$];
    logic [3:0] e;
    bit         all_diff, started = 0;
    int         cyc = 0, unlock_at = 0;

    ballot_input_conditioner #(.DEBOUNCE_CYCLES(D), .LOCKOUT_CYCLES(L)) dut (
        .clk(clk), .rst(rst), .btn_cand(btn_cand), .btn_confirm(btn_confirm),
        .btn_clear(btn_clear), .btn_arm(btn_arm), .vote_ready(vote_ready),
        .vote_valid(vote_valid), .vote_onehot(vote_onehot), .vote_idx(vote_idx),
        .sel_onehot(sel_onehot), .busy(busy), .err_pulse(err_pulse)
    );

    always #5 clk = ~clk;

    assign raw_in = {btn_arm, btn_clear, btn_confirm, btn_cand};

    function automatic int idx_of(logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(string name, int act, int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    // reference model: a button level flips once the last D synchronized samples all disagree with it
    always @(posedge clk) begin
        if (rst) begin
            if (mstate == M_SEND && exp_q.size() > 0) void'(exp_q.pop_back());
            mstate = M_IDLE;
            msel = '0;
            merr = 0;
            mdeb = '0;
            pend = '0;
            hist.delete();
            repeat (D + 1) hist.push_back('0);
            started = 1;
        end else begin
            merr = 0;
            case (mstate)
                M_IDLE: if (pend[6]) mstate = M_SELECT;
                M_SELECT: begin
                    if (pend[5]) msel = '0;
                    else if (pend[4]) begin
                        if (msel != 0) begin
                            mstate = M_SEND;
                            exp_q.push_back(msel);
                        end else merr = 1;
                    end else if (pend[3:0] != 0) begin
                        if ($countones(mdeb[3:0]) == 1) msel = mdeb[3:0];
                        else merr = 1;
                    end
                end
                M_SEND: if (vote_ready) begin
                    mstate = M_LOCK;
                    msel = '0;
                    unlock_at = cyc + L;
                end
                M_LOCK: if (cyc == unlock_at) mstate = M_IDLE;
            endcase
            pend = '0;
            for (int i = 0; i < 7; i++) begin
                all_diff = 1;
                for (int k = 0; k < D; k++) if (hist[k][i] == mdeb[i]) all_diff = 0;
                if (all_diff) begin
                    mdeb[i] = ~mdeb[i];
                    pend[i] = mdeb[i];
                end
            end
            hist.push_back(raw_in);
            void'(hist.pop_front());
        end
        cyc++;
    end

    // monitor: per-cycle output checks plus scoreboard pop on each handshake
    always @(negedge clk) begin
        if (started) begin
            chk("vote_valid", vote_valid, mstate == M_SEND);
            chk("vote_onehot", vote_onehot, mstate == M_SEND ? msel : 4'd0);
            chk("vote_idx", vote_idx, mstate == M_SEND ? idx_of(msel) : 0);
            chk("sel_onehot", sel_onehot, msel);
            chk("busy", busy, mstate != M_IDLE);
            chk("err_pulse", err_pulse, merr);
            if (vote_valid && vote_ready && !rst) begin
                if (exp_q.size() == 0) chk("vote_q_occupancy", exp_q.size(), 1);
                else begin
                    e = exp_q.pop_front();
                    chk("sb_onehot", vote_onehot, e);
                    chk("sb_idx", vote_idx, idx_of(e));
                    votes++;
                end
            end
        end
    end

    // downstream readiness: random unless forced
    initial forever begin
        @(posedge clk);
        #1;
        vote_ready = ready_lo ? 1'b0 : ready_hi ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(logic [6:0] m, int hold, int gap);
        {btn_arm, btn_clear, btn_confirm, btn_cand} = raw_in | m;
        tick(hold);
        {btn_arm, btn_clear, btn_confirm, btn_cand} = raw_in & ~m;
        tick(gap);
    endtask

    initial begin
        logic [6:0] cand;
        int r;
        tick(3);
        rst = 0;
        ready_hi = 1;
        press(ARM, 8, 4);
        press(7'h04, 8, 4);
        press(CONF, 8, L + 10);
        ready_hi = 0;
        ready_lo = 1;
        press(ARM, 8, 4);
        press(7'h01, 8, 4);
        press(CONF, 8, 2);
        rst = 1;
        tick(1);
        rst = 0;
        press(ARM, 8, 4);
        press(7'h03, 8, 4);
        press(CONF, 8, 4);
        press(7'h08, 8, 4);
        press(CLR | CONF, 8, 4);
        press(7'h01, 8, 4);
        press(CONF, 8, 5);
        ready_lo = 0;
        tick(L + 10);
        for (int s = 0; s < 150; s++) begin
            press(ARM, $urandom_range(3, 8), $urandom_range(0, 4));
            r = $urandom_range(0, 9);
            cand = 7'(1 << $urandom_range(0, 3));
            if (r >= 8) begin
                press(cand, $urandom_range(1, D - 1), $urandom_range(1, 3));
                press(cand, $urandom_range(1, D - 1), $urandom_range(1, 3));
            end else begin
                if (r >= 6) cand = 7'($urandom_range(1, 15));
                press(cand, $urandom_range(D, D + 4), $urandom_range(0, 4));
            end
            if ($urandom_range(0, 4) == 0)
                press(7'(1 << $urandom_range(0, 3)), D + 2, 3);
            r = $urandom_range(0, 9);
            if (r == 0) press(CLR, D + 1, 2);
            else if (r == 1) press(CLR | CONF, D + 1, 2);
            else if (r == 2) press(CONF | 7'(1 << $urandom_range(0, 3)), D + 1, 2);
            press(CONF, $urandom_range(D, D + 3), $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) press(7'($urandom_range(1, 127)), D + 1, 2);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1;
                tick(1);
                rst = 0;
            end
            tick($urandom_range(0, L + 4));
        end
        ready_hi = 1;
        {btn_arm, btn_clear, btn_confirm, btn_cand} = '0;
        tick(D + L + 20);
        chk("scoreboard_drain", exp_q.size(), 0);
        chk("votes_seen", votes > 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
